snn_stream_driver: RTL and testbench
====================================

# snn_stream_driver

Host-side transmitter and readout for the spiking-network core's byte-load/execute protocol. It accepts a command plus a byte stream of weights and input spikes, and drives the core's 8-bit data bus and its weights-select and execute lines. It then runs the network for a programmed number of timesteps, counts output spikes per neuron and reports spike counts plus the winning class. It sits between a host interface (UART/SPI bridge or test harness) and the network core.

## Interface
- `INPUTS`, 16, input spikes per vector; multiple of 8
- `OUTPUTS`, 8, output neurons sampled from `spk_in`
- `WEIGHTS`, 768, total 1-bit weights in the core; multiple of 8
- `PIPE_LAT`, 3, warm-up execute cycles discarded before sampling
- `CNT_BITS`, 8, per-neuron saturating spike-counter width
- `clk` in 1, sole clock
- `reset` in 1, synchronous, active-high
- `cmd_valid` in 1 / `cmd_ready` out 1, command handshake
- `cmd_load_w` in 1, 1 = send weights before inputs
- `cmd_steps` in 8, counted timesteps
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 8, payload byte stream
- `data_out` out 8, to core data bus
- `weights_sel` out 1, to core weights-select line
- `execute` out 1, to core execute line (0 = load mode)
- `spk_in` in OUTPUTS, core spike outputs
- `res_valid` out 1, one-cycle result strobe
- `res_class` out $clog2(OUTPUTS), argmax index
- `res_counts` out OUTPUTS*CNT_BITS, neuron i at [i*CNT_BITS +: CNT_BITS]

## Operation
- States: IDLE, LOAD_W, LOAD_I, RUN, ARGMAX, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch steps and clear counters.
  - Next state is LOAD_W if `cmd_load_w`, otherwise LOAD_I.
- **LOAD_W / LOAD_I**
  - `s_ready`=1 until WEIGHTS/8 (LOAD_W) or INPUTS/8 (LOAD_I) bytes are accepted.
  - Each accepted byte is presented for exactly one cycle: `data_out`=byte, `execute`=0, `weights_sel`=1 in LOAD_W, 0 in LOAD_I.
  - Bytes pass in arrival order; the first byte is the core's lowest-index layer-0 weights.
  - Cycles without a transfer drive `execute`=1, `data_out`=0, so the core never shifts in a stray byte.
  - LOAD_W always continues to LOAD_I. LOAD_I goes to RUN after its last byte.
- **RUN**
  - `execute`=1 for `cmd_steps`+PIPE_LAT cycles, with run counter r = 0…steps+PIPE_LAT−1.
  - For r ≥ PIPE_LAT, each counter i increments when `spk_in[i]`=1.
  - Counters saturate at 2^CNT_BITS−1.
- **ARGMAX**
  - Sequential scan, one neuron per cycle, OUTPUTS cycles.
  - Strictly-greater compare, so the lowest index wins ties.
- **DONE**
  - `res_valid`=1 for one cycle with `res_class` and `res_counts` valid.
  - `res_counts`/`res_class` hold until the next command is accepted.
  - Next state is IDLE.
- `cmd_steps`=0: RUN lasts PIPE_LAT cycles, counts are all 0, `res_class`=0.
- Outside load transfers, `execute`=1 and the core free-runs. Residual membrane state is flushed by PIPE_LAT only partially; this is accepted behaviour.

## Timing
- **Reset values:** state IDLE, `data_out`=0, `weights_sel`=0, `execute`=1, `cmd_ready`=1, `s_ready`=0, `res_valid`=0, `res_class`=0, counts 0.
- **Reset mid-operation:** abandons the load or run immediately. The host must resend the full command and payload; the core keeps partially shifted data.
- All core-side outputs are registered. A byte accepted at edge k appears on `data_out`/`execute`=0 during cycle k+1.
- **Command acceptance:** command accepted at edge T gives `s_ready`=1 from cycle T+1.
- **Last input byte:**
  - Last input byte accepted at edge L gives RUN from cycle L+2; its load cycle is L+1.
  - `res_valid` is asserted at cycle L+2+steps+PIPE_LAT+OUTPUTS.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0). `s_valid` outside the load states is ignored.

## Structure
- `snn_pkg`: state enum, and byte-count localparams WEIGHT_BYTES = WEIGHTS/8 and INPUT_BYTES = INPUTS/8.
- Sub-module `spike_counter_bank`: OUTPUTS saturating counters with clear/enable and a flat output bus.
- The FSM, byte counter, run counter and argmax scan stay in the top module.

## Test plan
- **Reset values:** assert `reset` 2 cycles → all outputs at reset values; `execute`=1, `cmd_ready`=1.
- **Weight load with gaps:** `cmd_load_w`=1, steps=10, 98 bytes with random `s_valid` gaps.
  - Exactly 98 one-cycle `execute`=0 pulses.
  - `weights_sel`=1 on the first 96 pulses only.
  - `data_out` sequence equals the sent bytes.
- **Single neuron, class 2:** core stub `spk_in`=8'h04 constant, steps=10, `cmd_load_w`=0 → counts[2]=10, others 0, `res_class`=2.
  - `res_valid` exactly 10+3+8 cycles after RUN entry.
- **Tie:** `spk_in`=8'h81, steps=5 → counts[0]=counts[7]=5, `res_class`=0.
- **Saturation and zero steps:**
  - CNT_BITS=4, steps=20, `spk_in`=8'hFF → all counts 15.
  - steps=0 → all counts 0, `res_class`=0.
- **Reset mid-load:** reset after 40 of 96 weight bytes → IDLE, `s_ready`=0, `cmd_ready`=1.
  - A new full command then completes normally.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and sizes for the spiking-network stream driver.
// Byte counts come from the core's fixed weight and input geometry.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_I,
    S_RUN,
    S_ARGMAX,
    S_DONE
  } state_e;

  localparam int INPUTS       = 16;
  localparam int WEIGHTS      = 768;
  localparam int WEIGHT_BYTES = WEIGHTS / 8;
  localparam int INPUT_BYTES  = INPUTS / 8;

endpackage

// File: rtl/snn_stream_driver_if.sv
// Host command/stream, core bus and result signals of the stream driver.
// The driver uses the slave modport; the host/harness drives the master side.
interface snn_stream_driver_if #(
  parameter int OUTPUTS  = 8,
  parameter int CNT_BITS = 8
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_load_w;
  logic [7:0]                   cmd_steps;
  logic                         s_valid;
  logic                         s_ready;
  logic [7:0]                   s_data;
  logic [7:0]                   data_out;
  logic                         weights_sel;
  logic                         execute;
  logic [OUTPUTS-1:0]           spk_in;
  logic                         res_valid;
  logic [$clog2(OUTPUTS)-1:0]   res_class;
  logic [OUTPUTS*CNT_BITS-1:0]  res_counts;

  modport slave (
    input  cmd_valid, cmd_load_w, cmd_steps, s_valid, s_data, spk_in,
    output cmd_ready, s_ready, data_out, weights_sel, execute,
           res_valid, res_class, res_counts
  );

  modport master (
    output cmd_valid, cmd_load_w, cmd_steps, s_valid, s_data, spk_in,
    input  cmd_ready, s_ready, data_out, weights_sel, execute,
           res_valid, res_class, res_counts
  );
endinterface

// File: rtl/snn_stream_driver_counter_bank.sv
// One saturating spike counter per output neuron, packed onto a flat bus
// with neuron i at [i*W +: W].
module spike_counter_bank #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [N-1:0] spk_i,
  output logic [N*W-1:0] cnt_o
);

  logic [W-1:0] cnt_q [N];

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < N; i++) begin
        if (spk_i[i] && (cnt_q[i] != {W{1'b1}})) cnt_q[i] <= cnt_q[i] + W'(1);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign cnt_o[g*W +: W] = cnt_q[g];
  end

endmodule

// File: rtl/snn_stream_driver.sv
// Loads weights/inputs into the spiking core byte by byte, runs it for a
// programmed number of timesteps, then reports spike counts and the argmax.
module snn_stream_driver
  import snn_pkg::*;
#(
  parameter int OUTPUTS  = 8,
  parameter int PIPE_LAT = 3,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  snn_stream_driver_if.slave  bus
);

  localparam int BC_W  = $clog2(WEIGHT_BYTES + 1);
  localparam int IDX_W = $clog2(OUTPUTS);
  localparam int RUN_W = 10;

  state_e                state_q, state_d;
  logic [BC_W-1:0]       bytes_q, bytes_d;
  logic [RUN_W-1:0]      run_q, run_d, run_last;
  logic [7:0]            steps_q, steps_d;
  logic [IDX_W-1:0]      idx_q, idx_d, best_q, best_d;
  logic [CNT_BITS-1:0]   best_cnt_q, best_cnt_d, cur_cnt;
  logic [7:0]            data_out_q, data_out_d;
  logic                  wsel_q, wsel_d, exec_q, exec_d;
  logic                  cmd_ready, s_ready, res_valid, accept;
  logic                  cnt_clear, cnt_en;
  logic [OUTPUTS*CNT_BITS-1:0] counts;

  spike_counter_bank #(.N(OUTPUTS), .W(CNT_BITS)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .spk_i   (bus.spk_in),
    .cnt_o   (counts)
  );

  assign run_last = RUN_W'(steps_q) + RUN_W'(PIPE_LAT) - RUN_W'(1);
  assign cur_cnt  = counts[idx_q*CNT_BITS +: CNT_BITS];
  assign s_ready  = ((state_q == S_LOAD_W) && (bytes_q != BC_W'(WEIGHT_BYTES))) ||
                    ((state_q == S_LOAD_I) && (bytes_q != BC_W'(INPUT_BYTES)));
  assign accept   = bus.s_valid && s_ready;

  // A load state lingers one cycle after its last byte so the byte is
  // presented on the bus before the next phase begins.
  always_comb begin
    state_d    = state_q;
    bytes_d    = bytes_q;
    run_d      = run_q;
    steps_d    = steps_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_cnt_d = best_cnt_q;
    data_out_d = 8'h00;
    wsel_d     = 1'b0;
    exec_d     = 1'b1;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          steps_d    = bus.cmd_steps;
          cnt_clear  = 1'b1;
          bytes_d    = '0;
          best_d     = '0;
          best_cnt_d = '0;
          state_d    = bus.cmd_load_w ? S_LOAD_W : S_LOAD_I;
        end
      end
      S_LOAD_W, S_LOAD_I: begin
        if (accept) begin
          bytes_d    = bytes_q + BC_W'(1);
          data_out_d = bus.s_data;
          wsel_d     = (state_q == S_LOAD_W);
          exec_d     = 1'b0;
        end else if (!s_ready) begin
          bytes_d = '0;
          run_d   = '0;
          state_d = (state_q == S_LOAD_W) ? S_LOAD_I : S_RUN;
        end
      end
      S_RUN: begin
        cnt_en = (run_q >= RUN_W'(PIPE_LAT));
        if (run_q == run_last) begin
          idx_d   = '0;
          state_d = S_ARGMAX;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      S_ARGMAX: begin
        if (cur_cnt > best_cnt_q) begin
          best_d     = idx_q;
          best_cnt_d = cur_cnt;
        end
        if (idx_q == IDX_W'(OUTPUTS - 1)) state_d = S_DONE;
        else idx_d = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bytes_q    <= '0;
      run_q      <= '0;
      steps_q    <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_cnt_q <= '0;
      data_out_q <= 8'h00;
      wsel_q     <= 1'b0;
      exec_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bytes_q    <= bytes_d;
      run_q      <= run_d;
      steps_q    <= steps_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_cnt_q <= best_cnt_d;
      data_out_q <= data_out_d;
      wsel_q     <= wsel_d;
      exec_q     <= exec_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.s_ready     = s_ready;
  assign bus.res_valid   = res_valid;
  assign bus.data_out    = data_out_q;
  assign bus.weights_sel = wsel_q;
  assign bus.execute     = exec_q;
  assign bus.res_class   = best_q;
  assign bus.res_counts  = counts;

endmodule

// File: tb/tb_snn_stream_driver.sv
// Directed bench: two drivers (8-bit and 4-bit counters) share one stimulus
// stream; load pulses on the core bus are captured and checked against sent bytes.
module tb_snn_stream_driver;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sent [$];
  logic [7:0] pulseData [$];
  logic       pulseSel [$];

  snn_stream_driver_if #(.OUTPUTS(8), .CNT_BITS(8)) bus ();
  snn_stream_driver_if #(.OUTPUTS(8), .CNT_BITS(4)) bus4 ();

  snn_stream_driver #(.OUTPUTS(8), .PIPE_LAT(3), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  snn_stream_driver #(.OUTPUTS(8), .PIPE_LAT(3), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave));

  assign bus4.cmd_valid  = bus.cmd_valid;
  assign bus4.cmd_load_w = bus.cmd_load_w;
  assign bus4.cmd_steps  = bus.cmd_steps;
  assign bus4.s_valid    = bus.s_valid;
  assign bus4.s_data     = bus.s_data;
  assign bus4.spk_in     = bus.spk_in;

  always #5 clk = ~clk;

  // Every execute-low cycle is one byte shifted into the core.
  always @(negedge clk) begin
    if (bus.execute === 1'b0) begin
      pulseData.push_back(bus.data_out);
      pulseSel.push_back(bus.weights_sel);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic loadW, input logic [7:0] steps);
    bus.cmd_valid  = 1'b1;
    bus.cmd_load_w = loadW;
    bus.cmd_steps  = steps;
    checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("s_ready_after_cmd", bus.s_ready, 1);
    checkOutput("cmd_ready_busy", bus.cmd_ready, 0);
  endtask

  task automatic sendBytes(input int n);
    logic [7:0] b;
    int w;
    sent.delete();
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      b = 8'($urandom);
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      w = 0;
      while (!bus.s_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        checkOutput("s_ready_timeout", 0, 1);
        bus.s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      sent.push_back(b);
    end
  endtask

  task automatic runVector(input logic loadW, input logic [7:0] steps, input logic [7:0] spk,
                           input logic [2:0] expClass, input logic [63:0] expCounts);
    int cycles;
    bus.spk_in = spk;
    applyStimulus(loadW, steps);
    sendBytes(loadW ? 98 : 2);
    cycles = 0;
    while (!bus.res_valid && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("res_latency", 64'(cycles), 64'(1 + int'(steps) + 3 + 8));
    checkOutput("res_class", bus.res_class, expClass);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("count%0d", i), bus.res_counts[i*8 +: 8], expCounts[i*8 +: 8]);
    @(negedge clk);
    checkOutput("res_valid_one_cycle", bus.res_valid, 0);
    checkOutput("res_class_hold", bus.res_class, expClass);
    checkOutput("res_counts_hold", bus.res_counts, expCounts);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_load_w = 1'b0;
    bus.cmd_steps  = 8'd0;
    bus.s_valid    = 1'b0;
    bus.s_data     = 8'h00;
    bus.spk_in     = 8'h00;
    reset          = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset values");
    checkOutput("rst_data_out", bus.data_out, 0);
    checkOutput("rst_weights_sel", bus.weights_sel, 0);
    checkOutput("rst_execute", bus.execute, 1);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_s_ready", bus.s_ready, 0);
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_res_class", bus.res_class, 0);
    checkOutput("rst_res_counts", bus.res_counts, 0);

    $display("[TB] weight load with gaps");
    pulseData.delete();
    pulseSel.delete();
    runVector(1'b1, 8'd10, 8'h00, 3'd0, 64'h0);
    checkOutput("pulse_count", 64'(pulseData.size()), 98);
    for (int i = 0; i < 98 && i < pulseData.size() && i < sent.size(); i++) begin
      checkOutput($sformatf("pulse_data%0d", i), pulseData[i], sent[i]);
      checkOutput($sformatf("pulse_sel%0d", i), pulseSel[i], (i < 96) ? 1 : 0);
    end

    $display("[TB] single neuron and tie");
    runVector(1'b0, 8'd10, 8'h04, 3'd2, 64'h0000_0000_000A_0000);
    runVector(1'b0, 8'd5,  8'h81, 3'd0, 64'h0500_0000_0000_0005);

    $display("[TB] saturation and zero steps");
    runVector(1'b0, 8'd20, 8'hFF, 3'd0, 64'h1414_1414_1414_1414);
    checkOutput("sat4_counts", bus4.res_counts, 64'hFFFF_FFFF);
    checkOutput("sat4_class", bus4.res_class, 0);
    runVector(1'b0, 8'd0, 8'hFF, 3'd0, 64'h0);
    checkOutput("zero4_counts", bus4.res_counts, 0);

    $display("[TB] reset mid-load");
    bus.spk_in = 8'h10;
    applyStimulus(1'b1, 8'd3);
    sendBytes(40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("midrst_s_ready", bus.s_ready, 0);
    checkOutput("midrst_execute", bus.execute, 1);
    checkOutput("midrst_data_out", bus.data_out, 0);
    pulseData.delete();
    pulseSel.delete();
    runVector(1'b1, 8'd3, 8'h10, 3'd4, 64'h0000_0003_0000_0000);
    checkOutput("midrst_pulse_count", 64'(pulseData.size()), 98);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
